// File: rtl/led_fade_trail_if.sv
// Chaser-to-LED bus: head position and brightness in, PWM drive and status out.
interface led_fade_trail_if #(
    parameter int NUM_LEDS = 6,
    parameter int PWM_BITS = 8
);
    logic                enable;
    logic [NUM_LEDS-1:0] pos_in;
    logic [PWM_BITS-1:0] global_bright;
    logic [NUM_LEDS-1:0] led_out;
    logic                frame_sync;
    logic                pos_err;

    modport master (output enable, pos_in, global_bright,
                    input  led_out, frame_sync, pos_err);
    modport slave  (input  enable, pos_in, global_bright,
                    output led_out, frame_sync, pos_err);
endinterface

// File: rtl/led_fade_trail.sv
// Per-LED PWM with a geometric fade behind the chaser head.
// Levels only move on frame boundaries so a PWM frame never sees a mid-frame level change.
module led_fade_lane #(
    parameter int PWM_BITS    = 8,
    parameter int DECAY_SHIFT = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable_i,
    input  logic                boundary_i,
    input  logic                decay_i,
    input  logic                head_i,
    input  logic [PWM_BITS-1:0] bright_i,
    input  logic [PWM_BITS-1:0] pwm_cnt_i,
    output logic                led_o
);
    logic [PWM_BITS-1:0] lvl_q, lvl_d;
    logic                led_q, led_d;

    always_comb begin
        lvl_d = lvl_q;
        if (boundary_i) begin
            if (head_i)       lvl_d = bright_i;
            else if (decay_i) lvl_d = lvl_q >> DECAY_SHIFT;
        end
        led_d = enable_i && (pwm_cnt_i < lvl_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lvl_q <= '0;
            led_q <= 1'b0;
        end else begin
            lvl_q <= lvl_d;
            led_q <= led_d;
        end
    end

    assign led_o = led_q;
endmodule

module led_fade_trail #(
    parameter int NUM_LEDS     = 6,
    parameter int PWM_BITS     = 8,
    parameter int DECAY_FRAMES = 16,
    parameter int DECAY_SHIFT  = 1
) (
    input  logic             clk,
    input  logic             reset,
    led_fade_trail_if.slave  bus
);
    localparam int FC_W = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;

    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [FC_W-1:0]     frame_cnt_q, frame_cnt_d;
    logic                frame_sync_q, frame_sync_d;
    logic                pos_err_q, pos_err_d;
    logic                boundary, decay_now, multi_hot;
    logic [NUM_LEDS-1:0] led_w;

    always_comb begin
        boundary     = bus.enable && (pwm_cnt_q == '1);
        decay_now    = (frame_cnt_q == FC_W'(DECAY_FRAMES - 1));
        // x & (x-1) clears the lowest set bit; anything left means two or more heads
        multi_hot    = (bus.pos_in & (bus.pos_in - NUM_LEDS'(1))) != '0;
        pwm_cnt_d    = bus.enable ? pwm_cnt_q + PWM_BITS'(1) : pwm_cnt_q;
        frame_cnt_d  = frame_cnt_q;
        if (boundary) frame_cnt_d = decay_now ? '0 : frame_cnt_q + FC_W'(1);
        frame_sync_d = boundary;
        pos_err_d    = pos_err_q || (boundary && multi_hot);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt_q    <= '0;
            frame_cnt_q  <= '0;
            frame_sync_q <= 1'b0;
            pos_err_q    <= 1'b0;
        end else begin
            pwm_cnt_q    <= pwm_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            frame_sync_q <= frame_sync_d;
            pos_err_q    <= pos_err_d;
        end
    end

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_lane
        led_fade_lane #(
            .PWM_BITS    (PWM_BITS),
            .DECAY_SHIFT (DECAY_SHIFT)
        ) u_lane (
            .clk        (clk),
            .reset      (reset),
            .enable_i   (bus.enable),
            .boundary_i (boundary),
            .decay_i    (decay_now),
            .head_i     (bus.pos_in[i]),
            .bright_i   (bus.global_bright),
            .pwm_cnt_i  (pwm_cnt_q),
            .led_o      (led_w[i])
        );
    end

    assign bus.led_out    = led_w;
    assign bus.frame_sync = frame_sync_q;
    assign bus.pos_err    = pos_err_q;
endmodule

// File: doc/led_fade_trail.md
Name: led_fade_trail

Overview:
- Downstream of the light-chaser stage. Consumes its one-hot LED position vector.
- Drives the physical LEDs with per-LED PWM, giving a fading "comet tail" behind the lit position.
- Each LED hit by the head loads full brightness, then decays geometrically on a frame-based timebase.
- Sits between the chaser FSM and the board LED pins.

Parameters:
- NUM_LEDS, 6, number of LED channels; equals the width of the chaser position vector.
- PWM_BITS, 8, width of the PWM counter and of each brightness level.
- DECAY_FRAMES, 16, number of PWM frames between decay steps (>=1).
- DECAY_SHIFT, 1, right-shift applied to each non-head level per decay step (>=1).

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous, active-high.
- enable, input, 1, run control; low freezes the block and blanks the LEDs.
- pos_in, input, NUM_LEDS, one-hot head position from the chaser (bit i = LED i).
- global_bright, input, PWM_BITS, brightness loaded into a head LED.
- led_out, output, NUM_LEDS, registered PWM drive to the LED pins.
- frame_sync, output, 1, single-cycle pulse on the last count of each PWM frame.
- pos_err, output, 1, sticky flag: pos_in had more than one bit set.

Behaviour:
Reset:
- Reset is synchronous, active-high; clock is clk.
- On reset: pwm_cnt=0, frame_cnt=0, all lvl[i]=0, led_out=0, frame_sync=0, pos_err=0.
- Reset has priority over enable. Asserting reset mid-operation zeroes everything on the next edge.

PWM counter:
- pwm_cnt is PWM_BITS wide and increments by 1 each cycle while enable=1.
- It wraps from 2^PWM_BITS-1 to 0, so one frame is 2^PWM_BITS enabled cycles.
- frame_sync is registered. It is 1 for exactly the cycle after an enabled edge on which pwm_cnt==max, and 0 otherwise.

Frame counter:
- frame_cnt counts 0..DECAY_FRAMES-1 and advances on each frame boundary.
- A frame boundary is an enabled cycle with pwm_cnt==max.
- decay_now = (frame_cnt==DECAY_FRAMES-1) at that boundary.

Level update (only at a frame boundary, so levels never change mid-frame):
- pos_in[i]=1: lvl[i] <= global_bright. A head load overrides decay.
- pos_in[i]=0 and decay_now: lvl[i] <= lvl[i] >> DECAY_SHIFT. This is a logical shift; the level reaches 0 and stays there.
- Otherwise: hold.
- pos_in is sampled only on boundary cycles. Head changes between boundaries are not seen.
- pos_in all-zero is legal: no head, all LEDs decay.
- pos_in with more than one bit set: every set bit is treated as a head, and pos_err is set and held until reset.
- A global_bright change affects only subsequent head loads.

Output:
- led_out[i] <= enable & (pwm_cnt < lvl[i]). The comparison is unsigned, and the output lags pwm_cnt by one cycle.
- lvl=0 gives the LED always off.
- lvl=max gives on for 2^PWM_BITS-1 of 2^PWM_BITS cycles. There is never 100% duty.

enable=0:
- pwm_cnt, frame_cnt, lvl and pos_err hold.
- frame_sync=0; led_out=0 from the next edge.
- Re-enable resumes from the held pwm_cnt, with no frame restart.

Test Plan:
(Bench params: NUM_LEDS=6, PWM_BITS=4, DECAY_FRAMES=2, DECAY_SHIFT=1.)
1. Reset: assert reset 3 cycles with random inputs -> led_out=0, frame_sync=0, pos_err=0. First frame_sync comes 16 cycles after enable rises.
2. Head load: enable=1, pos_in=000001, global_bright=15 -> after the first boundary, led_out[0] is high 15 of every 16 cycles and led_out[5:1]=0. frame_sync period is exactly 16 cycles.
3. Decay tail: as test 2, then switch pos_in=000010 -> at the next decay boundaries lvl[0] goes 15, 7, 3, 1, 0 (one step per 2 frames). led_out[0] duty is 7/16, 3/16, 1/16, 0, while led_out[1] is at 15/16.
4. Enable freeze: drop enable mid-frame at pwm_cnt=5 for 10 cycles -> led_out=0 one cycle later and frame_sync stays 0. After re-enable, the next frame_sync arrives 11 cycles later and lvl is unchanged.
5. Multi-hot: pos_in=000011 at a boundary -> lvl[0]=lvl[1]=global_bright and pos_err=1. Back to one-hot: pos_err stays 1 until reset.
6. Reset mid-run: with lvl[0]=15 and lvl[1]=7, assert reset for 1 cycle -> the next edge gives all outputs 0 and lvl 0. Restart behaves as in test 1.
